alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one 32-bit ALU (f[2:0] op select; y, zero outputs) between two requesters,
//   e.g. the main datapath and a multi-cycle multiply/divide sequencer.
// - Round-robin (or fixed-priority) arbitration with a valid/ready request handshake.
// - Operands and result are registered; one transaction is in flight at a time.
// - Sits between the requesters and the ALU instance in the CPU core.
// PARAMETERS
// - WIDTH  32  operand/result width; the ALU port widths match it.
// - RR_EN  1   1 = round-robin between req0/req1; 0 = fixed priority, req0 wins.
// PORTS
// - clk          in   1      rising-edge clock
// - reset_n      in   1      asynchronous, active-low reset
// - req_valid    in   2      per-requester request valid; bit i = requester i
// - req_ready    out  2      per-requester accept; at most one bit high per cycle
// - req_a        in   2xWIDTH  operand a; slice [i] belongs to requester i
// - req_b        in   2xWIDTH  operand b; slice [i] belongs to requester i
// - req_f        in   2x3      ALU op; slice [i] belongs to requester i
// - alu_a        out  WIDTH  to ALU operand a
// - alu_b        out  WIDTH  to ALU operand b
// - alu_f        out  3      to ALU op select
// - alu_y        in   WIDTH  ALU result (combinational)
// - alu_zero     in   1      ALU zero flag
// - rsp_valid    out  1      response valid
// - rsp_id       out  1      requester index that owns the response
// - rsp_y        out  WIDTH  registered result
// - rsp_zero     out  1      registered zero flag
// - rsp_err      out  1      illegal-op flag; see CONFIGURATION
// - rsp_ready    in   1      consumer accepts the response
// BEHAVIOUR
// - FSM states: IDLE, EXEC, RESP. Reset (reset_n=0, async) -> IDLE.
// - Reset values: all outputs 0, including rsp_valid, req_ready, alu_a/b, alu_f=3'b000,
//   rsp_y, rsp_zero, rsp_err and rsp_id. The round-robin pointer resets to 0,
//   so req0 has priority first.
// - IDLE
//   - req_ready is combinational: the grant bit for the winning valid requester.
//   - Handshake: valid&ready in cycle N latches a/b/f/id into the op registers;
//     the FSM moves to EXEC.
//   - Winner when both bits are valid: RR_EN=1 -> requester != last_grant; RR_EN=0 -> req0.
//   - On a grant, last_grant <= granted index.
// - EXEC (cycle N+1)
//   - alu_a/b/f are driven from the op registers. These are held constant at all other
//     times, so the ALU does not toggle.
//   - At the clock edge, alu_y/alu_zero are captured into rsp_y/rsp_zero and the FSM moves to RESP.
// - RESP (from cycle N+2)
//   - rsp_valid=1. rsp_y, rsp_zero, rsp_err and rsp_id stay stable until rsp_ready=1.
//   - On rsp_valid&rsp_ready the FSM returns to IDLE.
//   - Minimum request-to-request spacing: 3 cycles.
// - req_ready=0 in EXEC and RESP. Requesters must hold valid and operands until accepted.
// - No combinational path from req_* to rsp_*. Latency from accept to rsp_valid is 2 cycles.
// - Async reset mid-transaction drops the in-flight op silently; no response is produced.
// - Arithmetic, including wrap-around, is entirely the ALU's. The block does not modify y or zero.
// CONFIGURATION
// - Macro: ALU_ILLEGAL_OP_TRAP_EN
// - Defined: a request with f=3'b011 (undefined op) skips EXEC and goes IDLE->RESP directly.
//   - Response: rsp_err=1, rsp_y=0, rsp_zero=0.
//   - The ALU inputs are not updated for that op.
// - Undefined: f=3'b011 is executed like any other op, and rsp_err is tied to 0.
// TESTING
// - T1: reset_n=0 mid-EXEC -> all outputs 0 immediately; after release, req0 has priority first.
// - T2: req0 valid, a=5, b=3, f=2 -> accepted at cycle N; alu_a=5 at N+1;
//   rsp_valid at N+2 with rsp_y=8, rsp_zero=0, rsp_id=0.
// - T3: both valid continuously, f=6, a=b=7, RR_EN=1 -> grants alternate 0,1,0,1;
//   each rsp_y=0, rsp_zero=1. With RR_EN=0 -> all grants go to req0.
// - T4: response stall -> rsp_ready=0 for 5 cycles with f=7, a=1, b=2.
//   rsp_y=1 is held stable and req_ready=0 throughout; accept occurs 1 cycle after rsp_ready.
// - T5: f=3'b011 with the macro defined -> rsp_err=1, rsp_y=0, response 1 cycle after accept.
//   Without the macro -> 2-cycle latency and rsp_err=0.
// - T6: req1 drops valid before grant (req0 granted, RR_EN=1) -> no req1 response issued;
//   the next grant goes to req1 only once req1 is valid again.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response signals between two requesters, one ALU and the arbiter.
// The arbiter connects through the slave modport; requesters, the ALU and the consumer use master.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][WIDTH-1:0] req_a;
    logic [1:0][WIDTH-1:0] req_b;
    logic [1:0][2:0]       req_f;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_f;
    logic [WIDTH-1:0]      alu_y;
    logic                  alu_zero;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_zero;
    logic                  rsp_err;
    logic                  rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, req_f, alu_y, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_f, alu_y, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU: one registered transaction in flight.
// Optional macro ALU_ILLEGAL_OP_TRAP_EN: op 3'b011 is answered with rsp_err instead of executing.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_share_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_prio;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [2:0]       r_op_f;
    logic             r_op_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    logic [1:0]       w_pick;
    logic [1:0]       w_grant;
    logic             w_gnt_id;
    logic             w_accept;
    logic             w_trap;

    // Winner among the valid requesters; r_prio names the requester favoured on a tie
    always_comb begin
        w_pick = 2'b00;
        case (bus.req_valid)
            2'b01:   w_pick = 2'b01;
            2'b10:   w_pick = 2'b10;
            2'b11: begin
                if (RR_EN && r_prio) begin
                    w_pick = 2'b10;
                end else begin
                    w_pick = 2'b01;
                end
            end
            default: w_pick = 2'b00;
        endcase
    end

    // Grants only exist in IDLE and never while reset is asserted
    assign w_grant  = ((r_state == ST_IDLE) && reset_n) ? w_pick : 2'b00;
    assign w_gnt_id = w_grant[1];
    assign w_accept = |w_grant;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    localparam logic [2:0] OP_ILLEGAL = 3'b011;
    assign w_trap = (bus.req_f[w_gnt_id] == OP_ILLEGAL);
`else
    assign w_trap = 1'b0;
`endif

    // Next-state selection for the IDLE/EXEC/RESP sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_trap ? ST_RESP : ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and round-robin priority pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_prio <= ~w_gnt_id;
            end
        end
    end

    // Operand registers double as the ALU drive, so the ALU only sees new values on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a  <= {WIDTH{1'b0}};
            r_op_b  <= {WIDTH{1'b0}};
            r_op_f  <= 3'b000;
            r_op_id <= 1'b0;
        end else if (w_accept) begin
            r_op_id <= w_gnt_id;
            if (!w_trap) begin
                r_op_a <= bus.req_a[w_gnt_id];
                r_op_b <= bus.req_b[w_gnt_id];
                r_op_f <= bus.req_f[w_gnt_id];
            end
        end
    end

    // Response registers: loaded from the ALU after EXEC or directly on a trapped op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= {WIDTH{1'b0}};
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_trap) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= w_gnt_id;
                        r_rsp_y     <= {WIDTH{1'b0}};
                        r_rsp_zero  <= 1'b0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_op_id;
                    r_rsp_y     <= bus.alu_y;
                    r_rsp_zero  <= bus.alu_zero;
                    r_rsp_err   <= 1'b0;
                end
                ST_RESP: begin
                    r_rsp_valid <= ~bus.rsp_ready;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.alu_a     = r_op_a;
    assign bus.alu_b     = r_op_b;
    assign bus.alu_f     = r_op_f;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a
// transaction-level model; a second fixed-priority instance runs saturated alongside.
module tb_alu_share_arbiter;
    localparam int W = 32;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fp_grants = 0;
    bit   fp_on = 1'b0;

    alu_share_arbiter_if #(.WIDTH(W)) bus ();
    alu_share_arbiter_if #(.WIDTH(W)) bus_fp ();

    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b1)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b0)) u_fp  (.clk(clk), .reset_n(reset_n), .bus(bus_fp));

    always #5 clk = ~clk;

    // Behaviour of the ALU that sits behind the arbiter
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] f);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return a - b;
            default: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
    endfunction

    assign bus.alu_y       = alu_fn(bus.alu_a, bus.alu_b, bus.alu_f);
    assign bus.alu_zero    = (bus.alu_y == {W{1'b0}});
    assign bus_fp.alu_y    = alu_fn(bus_fp.alu_a, bus_fp.alu_b, bus_fp.alu_f);
    assign bus_fp.alu_zero = (bus_fp.alu_y == {W{1'b0}});
    assign bus_fp.req_valid = 2'b11;
    assign bus_fp.req_a     = {W'(7), W'(7)};
    assign bus_fp.req_b     = {W'(7), W'(7)};
    assign bus_fp.req_f     = {3'd6, 3'd6};
    assign bus_fp.rsp_ready = 1'b1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one outstanding transaction, tie priority, held ALU inputs, pending response
    bit         m_busy;
    int         m_cnt;
    bit         m_prio;
    logic [W-1:0] m_alu_a, m_alu_b, m_y;
    logic [2:0] m_alu_f;
    logic       m_id, m_zero, m_err;
    logic [1:0] obs_ready;

    function automatic logic [1:0] pick(input logic [1:0] v, input bit prio);
        if (v == 2'b11) return prio ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] f);
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
        bus.req_f[i]     = f;
        bus.req_valid[i] = 1'b1;
    endtask

    // One clock: compare outputs against the model, advance the model, drop accepted requests
    task automatic cycle();
        logic [1:0] exp_ready;
        logic       exp_rv;
        int         id;
        #1;
        exp_ready = m_busy ? 2'b00 : pick(bus.req_valid, m_prio);
        exp_rv    = m_busy && (m_cnt == 0);
        obs_ready = bus.req_ready;
        check_val("req_ready", bus.req_ready, exp_ready);
        check_val("rsp_valid", bus.rsp_valid, exp_rv);
        check_val("alu_a", bus.alu_a, m_alu_a);
        check_val("alu_b", bus.alu_b, m_alu_b);
        check_val("alu_f", bus.alu_f, m_alu_f);
        if (exp_rv) begin
            check_val("rsp_id", bus.rsp_id, m_id);
            check_val("rsp_y", bus.rsp_y, m_y);
            check_val("rsp_zero", bus.rsp_zero, m_zero);
            check_val("rsp_err", bus.rsp_err, m_err);
        end
        if (!m_busy) begin
            if (exp_ready != 2'b00) begin
                id     = int'(exp_ready[1]);
                m_id   = exp_ready[1];
                m_prio = ~exp_ready[1];
                m_busy = 1'b1;
                if (TRAP && bus.req_f[id] == 3'b011) begin
                    m_cnt = 0; m_y = '0; m_zero = 1'b0; m_err = 1'b1;
                end else begin
                    m_alu_a = bus.req_a[id];
                    m_alu_b = bus.req_b[id];
                    m_alu_f = bus.req_f[id];
                    m_y     = alu_fn(m_alu_a, m_alu_b, m_alu_f);
                    m_zero  = (m_y == '0);
                    m_err   = 1'b0;
                    m_cnt   = 1;
                end
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (bus.rsp_ready) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
        if (exp_ready[0]) bus.req_valid[0] = 1'b0;
        if (exp_ready[1]) bus.req_valid[1] = 1'b0;
    endtask

    // Asserts reset (possibly mid-cycle), checks every output is zero at once, releases on a negedge
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_val("rst_req_ready", bus.req_ready, 2'b00);
        check_val("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_val("rst_rsp_id", bus.rsp_id, 1'b0);
        check_val("rst_rsp_y", bus.rsp_y, '0);
        check_val("rst_rsp_zero", bus.rsp_zero, 1'b0);
        check_val("rst_rsp_err", bus.rsp_err, 1'b0);
        check_val("rst_alu_a", bus.alu_a, '0);
        check_val("rst_alu_b", bus.alu_b, '0);
        check_val("rst_alu_f", bus.alu_f, 3'b000);
        m_busy = 1'b0; m_cnt = 0; m_prio = 1'b0;
        m_alu_a = '0; m_alu_b = '0; m_alu_f = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(3))
            0:       return '0;
            1:       return W'($urandom_range(15));
            2:       return {W{1'b1}} - W'($urandom_range(3));
            default: return W'($urandom);
        endcase
    endfunction

    // Fixed-priority instance sees both requesters valid forever: every grant must be req0
    always @(negedge clk) begin
        if (fp_on) begin
            #1;
            if (bus_fp.req_ready != 2'b00) begin
                fp_grants++;
                check_val("fp_grant", bus_fp.req_ready, 2'b01);
            end
            if (bus_fp.rsp_valid) begin
                check_val("fp_rsp_y", bus_fp.rsp_y, '0);
                check_val("fp_rsp_zero", bus_fp.rsp_zero, 1'b1);
                check_val("fp_rsp_id", bus_fp.rsp_id, 1'b0);
            end
        end
    end

    initial begin
        int k;
        logic [W-1:0] a, b;
        reset_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a = '0; bus.req_b = '0; bus.req_f = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        do_reset();
        bus.req_valid = 2'b00;
        fp_on = 1'b1;

        // Single req0 add: accept, ALU drive next cycle, response two cycles after accept
        bus.rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd3, 3'd2);
        cycle();
        check_val("t2_alu_a", bus.alu_a, 32'd5);
        check_val("t2_rsp_early", bus.rsp_valid, 1'b0);
        cycle();
        check_val("t2_rsp_valid", bus.rsp_valid, 1'b1);
        check_val("t2_rsp_y", bus.rsp_y, 32'd8);
        check_val("t2_rsp_zero", bus.rsp_zero, 1'b0);
        check_val("t2_rsp_id", bus.rsp_id, 1'b0);
        cycle();

        // Reset while the op is executing, then contention straight after release
        set_req(1, 32'h10, 32'h20, 3'd1);
        cycle();
        #2;
        do_reset();

        k = 0;
        for (int c = 0; c < 12; c++) begin
            set_req(0, 32'd7, 32'd7, 3'd6);
            set_req(1, 32'd7, 32'd7, 3'd6);
            cycle();
            if (obs_ready != 2'b00) begin
                check_val("t3_grant", obs_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
                k++;
            end
            if (bus.rsp_valid) begin
                check_val("t3_rsp_y", bus.rsp_y, '0);
                check_val("t3_rsp_zero", bus.rsp_zero, 1'b1);
            end
        end
        check_val("t3_grant_count", k, 4);
        bus.req_valid = 2'b00;
        cycle();
        cycle();

        // Response stall: result held and no grants until the consumer accepts
        bus.rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd2, 3'd7);
        cycle();
        set_req(1, 32'h55, 32'h66, 3'd2);
        cycle();
        for (int c = 0; c < 5; c++) begin
            check_val("t4_rsp_valid", bus.rsp_valid, 1'b1);
            check_val("t4_rsp_y", bus.rsp_y, 32'd1);
            check_val("t4_req_ready", bus.req_ready, 2'b00);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check_val("t4_next_grant", bus.req_ready, 2'b10);
        cycle();
        cycle();
        cycle();

        // Undefined op 3'b011
        set_req(0, 32'd9, 32'd4, 3'b011);
        cycle();
`ifdef ALU_ILLEGAL_OP_TRAP_EN
        check_val("t5_rsp_valid", bus.rsp_valid, 1'b1);
        check_val("t5_rsp_err", bus.rsp_err, 1'b1);
        check_val("t5_rsp_y", bus.rsp_y, '0);
        check_val("t5_rsp_zero", bus.rsp_zero, 1'b0);
        cycle();
`else
        check_val("t5_rsp_early", bus.rsp_valid, 1'b0);
        cycle();
        check_val("t5_rsp_valid", bus.rsp_valid, 1'b1);
        check_val("t5_rsp_err", bus.rsp_err, 1'b0);
        check_val("t5_rsp_y", bus.rsp_y, alu_fn(32'd9, 32'd4, 3'b011));
        cycle();
`endif

        // req1 withdraws while req0 is served: nothing for req1 until it asks again
        set_req(1, 32'd3, 32'd3, 3'd2);
        cycle();
        cycle();
        cycle();
        set_req(0, 32'd4, 32'd4, 3'd0);
        set_req(1, 32'd8, 32'd8, 3'd1);
        cycle();
        check_val("t6_first_grant", obs_ready, 2'b01);
        bus.req_valid[1] = 1'b0;
        cycle();
        cycle();
        for (int c = 0; c < 4; c++) begin
            cycle();
            check_val("t6_idle_ready", obs_ready, 2'b00);
            check_val("t6_no_rsp", bus.rsp_valid, 1'b0);
        end
        set_req(1, 32'd8, 32'd8, 3'd1);
        cycle();
        check_val("t6_req1_grant", obs_ready, 2'b10);
        cycle();
        cycle();

        // Random traffic with random consumer back-pressure
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i]) begin
                    if ($urandom_range(99) < 8) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(99) < 40) begin
                    a = rnd_val();
                    b = ($urandom_range(3) == 0) ? a : rnd_val();
                    set_req(i, a, b, 3'($urandom_range(7)));
                end
            end
            bus.rsp_ready = ($urandom_range(99) < 70);
            cycle();
        end

        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        fp_on = 1'b0;
        check_val("fp_grants_seen", (fp_grants >= 100), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
